multicycle_controller: RTL

Control unit for the multicycle variant of the RV32I core: a Moore FSM that sequences the shared datapath (one ALU, one unified instruction/data memory) across several cycles per instruction. It also decodes the ALU operation and immediate format. It drives every datapath enable and mux select, and stalls on a memory-ready handshake.

---
 rtl/multicycle_controller_pkg.sv | 55 +++++
 rtl/multicycle_controller_if.sv | 32 +++
 rtl/multicycle_controller_alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// State encodings are exported on state_dbg and must stay stable.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD = 2'b00,
        ALUOP_SUB = 2'b01,
        ALUOP_R   = 2'b10
    } aluop_e;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and datapath (slave).
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       ZERO;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] immSrc;
    logic       illegal_instr;
    logic [3:0] state_dbg;

    modport master (
        input  op, funct3, funct7b5, ZERO, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, immSrc, illegal_instr, state_dbg
    );

    modport slave (
        output op, funct3, funct7b5, ZERO, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, immSrc, illegal_instr, state_dbg
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps ALUOp plus instruction function fields to the ALU operation code.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  aluop_e     alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_R: begin
                case (funct3)
                    // Only R-type distinguishes sub; I-ALU with bit 30 set is still addi.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared multicycle RV32I datapath, plus immediate-format decode.
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic                      CLK,
    input  logic                      reset,
    multicycle_controller_if.master   bus
);

    state_e     state_q, state_d;
    aluop_e     alu_op;
    logic       pc_update;
    logic       branch;
    logic [2:0] alu_control;

    always_ff @(posedge CLK) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_IALU:      state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update         = 1'b0;
        branch            = 1'b0;
        alu_op            = ALUOP_ADD;
        bus.AdrSrc        = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.ResultSrc     = RES_ALUOUT;
        bus.ALUSrcA       = SRCA_PC;
        bus.ALUSrcB       = SRCB_B;
        bus.illegal_instr = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                bus.IRWrite   = bus.mem_ready;
                pc_update     = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW, OP_R, OP_IALU, OP_BEQ, OP_JAL: bus.illegal_instr = 1'b0;
                    default:                                      bus.illegal_instr = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_A;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECR: begin
                bus.ALUSrcA = SRCA_A;
                alu_op      = ALUOP_R;
            end
            S_EXECI: begin
                bus.ALUSrcA = SRCA_A;
                bus.ALUSrcB = SRCB_IMM;
                alu_op      = ALUOP_R;
            end
            S_ALUWB:    bus.RegWrite = 1'b1;
            S_BEQ: begin
                bus.ALUSrcA = SRCA_A;
                alu_op      = ALUOP_SUB;
                branch      = 1'b1;
            end
            S_JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                pc_update   = 1'b1;
            end
            default: ;
        endcase
        bus.PCWrite = pc_update | (branch & bus.ZERO);
        // Reset masks every state-changing strobe, even when it lands mid-instruction.
        if (reset) begin
            bus.PCWrite       = 1'b0;
            bus.IRWrite       = 1'b0;
            bus.MemWrite      = 1'b0;
            bus.RegWrite      = 1'b0;
            bus.illegal_instr = 1'b0;
        end
    end

    always_comb begin
        case (bus.op)
            OP_LW, OP_IALU: bus.immSrc = IMM_I;
            OP_SW:          bus.immSrc = IMM_S;
            OP_BEQ:         bus.immSrc = IMM_B;
            OP_JAL:         bus.immSrc = IMM_J;
            default:        bus.immSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .op5         (bus.op[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (alu_control)
    );

    assign bus.ALUControl = alu_control;
    assign bus.state_dbg  = state_q;

endmodule
